tcam_ctrl: RTL and testbench

Sequential ternary-CAM controller. Owns the entry storage (data, don't-care mask, valid bit per entry), arbitrates between one write requester and one search requester, and executes searches as a one-entry-per-cycle scan. Priority matches our combinational TCAM: the highest matching index wins. It sits between the lookup clients and the match-result consumers, replacing the single-cycle all-entry compare when timing or area forbids it.

---
 rtl/tcam_pkg.sv | 14 +
 rtl/tcam_ctrl_if.sv | 40 ++++
 rtl/tcam_entry_cmp.sv | 16 +
 rtl/tcam_ctrl.sv | 147 ++++++++++++++
 tb/tb_tcam_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tcam_pkg.sv
// Shared types and defaults for the sequential ternary-CAM controller.
// FSM encoding is fixed so the state can be probed by the existing TCAM tools.
package tcam_pkg;

  localparam int TCAM_N = 3;
  localparam int TCAM_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } tcam_state_e;

endpackage

// File: rtl/tcam_ctrl_if.sv
// Write/search request bundle and match-result outputs of tcam_ctrl.
// master = lookup/write client, slave = the controller.
interface tcam_ctrl_if
  import tcam_pkg::*;
#(
  parameter int N         = TCAM_N,
  parameter int WORD_SIZE = TCAM_W
);

  logic                 wr_req;
  logic [N-1:0]         wr_addr;
  logic [WORD_SIZE-1:0] wr_data;
  logic [WORD_SIZE-1:0] wr_data_x;
  logic                 wr_ack;

  logic                 srch_req;
  logic [WORD_SIZE-1:0] srch_data;
  logic [WORD_SIZE-1:0] srch_data_x;
  logic                 srch_ack;

  logic                 busy;
  logic                 done;
  logic                 match_flag;
  logic [N-1:0]         match_addr;

  modport master (
    output wr_req, wr_addr, wr_data, wr_data_x,
    output srch_req, srch_data, srch_data_x,
    input  wr_ack, srch_ack,
    input  busy, done, match_flag, match_addr
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, wr_data_x,
    input  srch_req, srch_data, srch_data_x,
    output wr_ack, srch_ack,
    output busy, done, match_flag, match_addr
  );

endinterface

// File: rtl/tcam_entry_cmp.sv
// Combinational ternary compare of one stored entry against a search key.
// A bit matches if either side marks it don't-care or the values agree.
module tcam_entry_cmp #(
  parameter int W = 8
) (
  input  logic [W-1:0] ent,
  input  logic [W-1:0] ent_x,
  input  logic         valid,
  input  logic [W-1:0] key,
  input  logic [W-1:0] key_x,
  output logic         hit
);

  assign hit = valid & (&(ent_x | key_x | ~(ent ^ key)));

endmodule

// File: rtl/tcam_ctrl.sv
// Sequential TCAM: entry storage, write/search arbiter, one-entry-per-cycle scan.
// Define TCAM_CTRL_EARLY_EXIT_EN to end the scan at the first (highest) hit.
module tcam_ctrl
  import tcam_pkg::*;
#(
  parameter int N         = TCAM_N,
  parameter int WORD_SIZE = TCAM_W
) (
  input  logic       clk,
  input  logic       rst_n,
  tcam_ctrl_if.slave bus
);

  localparam int DEPTH = 1 << N;

  typedef logic [WORD_SIZE-1:0] word_t;

  word_t            mem_q   [DEPTH];
  word_t            mem_x_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;

  tcam_state_e state_q, state_d;
  logic [N-1:0] idx_q, idx_d;
  logic [N-1:0] hit_addr_q, hit_addr_d;
  logic [N-1:0] match_addr_q, match_addr_d;
  word_t        key_q, key_d;
  word_t        key_x_q, key_x_d;
  logic         hit_q, hit_d;
  logic         prefer_q, prefer_d;
  logic         match_flag_q, match_flag_d;

  logic idle;
  logic wr_ack;
  logic srch_ack;
  logic ent_hit;
  logic first_hit;

  assign idle     = (state_q == ST_IDLE);
  assign wr_ack   = bus.wr_req & idle
                  & ~(bus.srch_req & prefer_q);
  assign srch_ack = bus.srch_req & idle & ~wr_ack;

  tcam_entry_cmp #(
    .W(WORD_SIZE)
  ) u_cmp (
    .ent   (mem_q[idx_q]),
    .ent_x (mem_x_q[idx_q]),
    .valid (valid_q[idx_q]),
    .key   (key_q),
    .key_x (key_x_q),
    .hit   (ent_hit)
  );

  assign first_hit = ent_hit & ~hit_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    key_d        = key_q;
    key_x_d      = key_x_q;
    hit_d        = hit_q;
    hit_addr_d   = hit_addr_q;
    prefer_d     = prefer_q;
    match_flag_d = match_flag_q;
    match_addr_d = match_addr_q;
    valid_d      = valid_q;

    if (wr_ack) valid_d[bus.wr_addr] = 1'b1;

    // a write that beats a waiting search hands the next tie to the search
    if (wr_ack && bus.srch_req) prefer_d = 1'b1;
    else if (srch_ack)          prefer_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (srch_ack) begin
          key_d      = bus.srch_data;
          key_x_d    = bus.srch_data_x;
          idx_d      = '1;
          hit_d      = 1'b0;
          hit_addr_d = '0;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        idx_d = idx_q - 1'b1;
        if (first_hit) begin
          hit_d      = 1'b1;
          hit_addr_d = idx_q;
        end
`ifdef TCAM_CTRL_EARLY_EXIT_EN
        if (first_hit || idx_q == '0) state_d = ST_DONE;
`else
        if (idx_q == '0) state_d = ST_DONE;
`endif
        if (state_d == ST_DONE) begin
          match_flag_d = hit_d;
          match_addr_d = hit_d ? hit_addr_d : '0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      key_q        <= '0;
      key_x_q      <= '0;
      hit_q        <= 1'b0;
      hit_addr_q   <= '0;
      prefer_q     <= 1'b0;
      match_flag_q <= 1'b0;
      match_addr_q <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      key_q        <= key_d;
      key_x_q      <= key_x_d;
      hit_q        <= hit_d;
      hit_addr_q   <= hit_addr_d;
      prefer_q     <= prefer_d;
      match_flag_q <= match_flag_d;
      match_addr_q <= match_addr_d;
      valid_q      <= valid_d;
    end
  end

  // entry payload is qualified by valid_q, so it needs no reset
  always_ff @(posedge clk) begin
    if (wr_ack) begin
      mem_q[bus.wr_addr]   <= bus.wr_data;
      mem_x_q[bus.wr_addr] <= bus.wr_data_x;
    end
  end

  assign bus.wr_ack     = wr_ack;
  assign bus.srch_ack   = srch_ack;
  assign bus.busy       = ~idle;
  assign bus.done       = (state_q == ST_DONE);
  assign bus.match_flag = match_flag_q;
  assign bus.match_addr = match_addr_q;

endmodule

// File: tb/tb_tcam_ctrl.sv
// Directed bench for tcam_ctrl: vector table of writes/searches
// plus arbitration, write-during-scan and mid-scan reset sequences.
module tb_tcam_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tcam_ctrl_if bus ();

  tcam_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit         wr;
    logic [2:0] addr;
    logic [7:0] d;
    logic [7:0] x;
    bit         ef;
    logic [2:0] ea;
  } vec_t;

  vec_t vt[12];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(bit f, logic [2:0] a);
`ifdef TCAM_CTRL_EARLY_EXIT_EN
    return f ? (9 - int'(a)) : 9;
`else
    return 9;
`endif
  endfunction

  function automatic vec_t mk(bit wr, logic [2:0] a,
      logic [7:0] d, logic [7:0] x, bit ef, logic [2:0] ea);
    vec_t v;
    v.wr = wr; v.addr = a; v.d = d; v.x = x;
    v.ef = ef; v.ea = ea;
    return v;
  endfunction

  task automatic do_write(logic [2:0] a, logic [7:0] d,
                          logic [7:0] x);
    bit g = 0;
    @(posedge clk); #1;
    bus.wr_req = 1; bus.wr_addr = a;
    bus.wr_data = d; bus.wr_data_x = x;
    for (int i = 0; i < 40 && !g; i++) begin
      @(negedge clk);
      if (bus.wr_ack) g = 1;
      else @(posedge clk);
    end
    if (!g) chk("wr_grant_timeout", 0, 1);
    @(posedge clk); #1;
    bus.wr_req = 0;
  endtask

  // waits for done from the cycle after the grant; lat counts cycles
  task automatic wait_done(output int lat, output bit ok);
    lat = 0; ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      lat++;
      if (bus.done) ok = 1;
    end
  endtask

  task automatic do_search(logic [7:0] k, logic [7:0] kx,
      output logic f, output logic [2:0] a, output int lat);
    bit g = 0;
    bit ok;
    f = 0; a = 0; lat = 0;
    @(posedge clk); #1;
    bus.srch_req = 1; bus.srch_data = k; bus.srch_data_x = kx;
    for (int i = 0; i < 40 && !g; i++) begin
      @(negedge clk);
      if (bus.srch_ack) g = 1;
      else @(posedge clk);
    end
    @(posedge clk); #1;
    bus.srch_req = 0;
    if (!g) begin
      chk("srch_grant_timeout", 0, 1);
      return;
    end
    wait_done(lat, ok);
    if (!ok) chk("done_timeout", 0, 1);
    f = bus.match_flag;
    a = bus.match_addr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       f;
    logic [2:0] a;
    int         lat;
    bit         ok;
    bit         seen;

    vt[0]  = mk(0, 0, 8'hAA, 8'h00, 0, 0);
    vt[1]  = mk(1, 2, 8'hA5, 8'h0F, 0, 0);
    vt[2]  = mk(1, 5, 8'hA0, 8'h00, 0, 0);
    vt[3]  = mk(0, 0, 8'hA3, 8'h00, 1, 2);
    vt[4]  = mk(0, 0, 8'hA0, 8'h00, 1, 5);
    vt[5]  = mk(1, 0, 8'h11, 8'h00, 0, 0);
    vt[6]  = mk(0, 0, 8'h11, 8'h00, 1, 0);
    vt[7]  = mk(0, 0, 8'h00, 8'hFF, 1, 5);
    vt[8]  = mk(1, 7, 8'h77, 8'h00, 0, 0);
    vt[9]  = mk(0, 0, 8'h77, 8'h00, 1, 7);
    vt[10] = mk(1, 1, 8'h00, 8'hFF, 0, 0);
    vt[11] = mk(0, 0, 8'h3C, 8'h00, 1, 1);

    bus.wr_req = 0; bus.wr_addr = 0;
    bus.wr_data = 0; bus.wr_data_x = 0;
    bus.srch_req = 0; bus.srch_data = 0; bus.srch_data_x = 0;

    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_flag", bus.match_flag, 0);
    chk("rst_addr", bus.match_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("idle_wr_ack", bus.wr_ack, 0);
    chk("idle_srch_ack", bus.srch_ack, 0);

    for (int i = 0; i < 12; i++) begin
      if (vt[i].wr) begin
        do_write(vt[i].addr, vt[i].d, vt[i].x);
      end else begin
        do_search(vt[i].d, vt[i].x, f, a, lat);
        chk($sformatf("v%0d_flag", i), f, vt[i].ef);
        chk($sformatf("v%0d_addr", i), a, vt[i].ea);
        chk($sformatf("v%0d_lat", i), lat,
            exp_lat(vt[i].ef, vt[i].ea));
      end
    end
    do_search(8'h5F, 8'h00, f, a, lat);
    chk("s5f_addr", a, 1);

    // simultaneous requests: write first, then search, then 2nd write
    @(posedge clk); #1;
    bus.wr_req = 1; bus.wr_addr = 3;
    bus.wr_data = 8'hC3; bus.wr_data_x = 0;
    bus.srch_req = 1; bus.srch_data = 8'hC3; bus.srch_data_x = 0;
    @(negedge clk);
    chk("tie_wr_ack", bus.wr_ack, 1);
    chk("tie_srch_ack0", bus.srch_ack, 0);
    @(posedge clk); #1;
    bus.wr_addr = 4; bus.wr_data = 8'h44;
    @(negedge clk);
    chk("tie_srch_ack1", bus.srch_ack, 1);
    chk("tie_wr_ack1", bus.wr_ack, 0);
    @(posedge clk); #1;
    bus.srch_req = 0;
    seen = 0; lat = 0; ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      lat++;
      if (bus.wr_ack) seen = 1;
      if (bus.done) ok = 1;
    end
    chk("tie_done", ok, 1);
    chk("tie_no_wr_in_scan", seen, 0);
    chk("tie_flag", bus.match_flag, 1);
    chk("tie_addr", bus.match_addr, 3);
    chk("tie_lat", lat, exp_lat(1, 3));
    @(negedge clk);
    chk("tie_wr2_ack", bus.wr_ack, 1);
    @(posedge clk); #1;
    bus.wr_req = 0;

    // write to entry 7 requested during a scan must wait for DONE
    @(posedge clk); #1;
    bus.srch_req = 1; bus.srch_data = 8'hE1; bus.srch_data_x = 0;
    @(negedge clk);
    chk("ws_srch_ack", bus.srch_ack, 1);
    @(posedge clk); #1;
    bus.srch_req = 0;
    bus.wr_req = 1; bus.wr_addr = 7;
    bus.wr_data = 8'hE1; bus.wr_data_x = 0;
    seen = 0; ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.wr_ack) seen = 1;
      if (bus.done) ok = 1;
    end
    chk("ws_done", ok, 1);
    chk("ws_no_wr_ack", seen, 0);
    chk("ws_addr", bus.match_addr, 1);
    @(negedge clk);
    chk("ws_wr_ack_after", bus.wr_ack, 1);
    @(posedge clk); #1;
    bus.wr_req = 0;
    do_search(8'hE1, 8'h00, f, a, lat);
    chk("ws_new_flag", f, 1);
    chk("ws_new_addr", a, 7);

    // reset in the 4th scan cycle
    @(posedge clk); #1;
    bus.srch_req = 1; bus.srch_data = 8'hA0; bus.srch_data_x = 0;
    @(negedge clk);
    chk("rs_srch_ack", bus.srch_ack, 1);
    @(posedge clk); #1;
    bus.srch_req = 0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("rs_busy_pre", bus.busy, 1);
    rst_n = 0;
    #1;
    chk("rs_busy", bus.busy, 0);
    chk("rs_done", bus.done, 0);
    chk("rs_flag", bus.match_flag, 0);
    chk("rs_addr", bus.match_addr, 0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1;
    end
    chk("rs_quiet", seen, 0);
    rst_n = 1;
    do_search(8'hA0, 8'h00, f, a, lat);
    chk("rs_miss_flag", f, 0);
    chk("rs_miss_addr", a, 0);
    chk("rs_miss_lat", lat, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
